// File: rtl/mem_write_buffer.sv
// Line-granular write buffer between the L2 and memory: absorbs and coalesces
// dirty-line write-backs, forwards read hits, and lets read misses overtake queued drains.
module mem_write_buffer #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned LINE_W   = 128,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     up_valid_i,
    input  logic                     up_rw_i,
    input  logic [ADDR_W-1:0]        up_addr_i,
    input  logic [LINE_W-1:0]        up_wdata_i,
    output logic                     up_ready_o,
    output logic [LINE_W-1:0]        up_rdata_o,
    output logic                     mem_valid_o,
    output logic                     mem_rw_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [LINE_W-1:0]        mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [LINE_W-1:0]        mem_rdata_i,
    input  logic                     flush_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              no_coal_o,
    output logic [31:0]              no_fwd_o
);

    localparam int unsigned TAG_W = ADDR_W - OFFSET_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {U_IDLE, U_RDWAIT, U_RESP} u_state_e;
    typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} m_state_e;

    u_state_e            u_state_q, u_state_d;
    m_state_e            m_state_q, m_state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [DEPTH];
    logic [TAG_W-1:0]    tag_d  [DEPTH];
    logic [LINE_W-1:0]   data_q [DEPTH];
    logic [LINE_W-1:0]   data_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;
    logic [31:0]         coal_q, coal_d;
    logic [31:0]         fwd_q, fwd_d;

    logic [TAG_W-1:0]    up_tag;
    logic                hit;
    logic [PTR_W-1:0]    hit_idx;
    logic                head_inflight;
    logic                push;
    logic                pop;

    assign up_tag = up_addr_i[ADDR_W-1:OFFSET_W];

    // Tag lookup; at most one valid entry per tag, so no priority is needed
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == up_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // The head entry is frozen while its drain is on the memory port
    assign head_inflight = (m_state_q == M_WR) && (hit_idx == head_q);

    always_comb begin
        u_state_d = u_state_q;
        m_state_d = m_state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        coal_d    = coal_q;
        fwd_d     = fwd_q;
        push      = 1'b0;
        pop       = 1'b0;

        case (u_state_q)
            U_IDLE: begin
                if (up_valid_i) begin
                    if (up_rw_i) begin
                        if (hit && !head_inflight) begin
                            data_d[hit_idx] = up_wdata_i;
                            coal_d          = coal_q + 32'd1;
                            u_state_d       = U_RESP;
                        end else if (!hit && (count_q < CNT_W'(DEPTH))) begin
                            push      = 1'b1;
                            u_state_d = U_RESP;
                        end
                    end else begin
                        if (hit) begin
                            rdata_d   = data_q[hit_idx];
                            fwd_d     = fwd_q + 32'd1;
                            u_state_d = U_RESP;
                        end else begin
                            rd_pend_d = 1'b1;
                            rd_addr_d = up_addr_i;
                            u_state_d = U_RDWAIT;
                        end
                    end
                end
            end
            U_RDWAIT: begin
                if ((m_state_q == M_RD) && mem_ready_i) begin
                    rdata_d   = mem_rdata_i;
                    u_state_d = U_RESP;
                end
            end
            U_RESP:  u_state_d = U_IDLE;
            default: u_state_d = U_IDLE;
        endcase

        // Read misses take the port ahead of drains unless flushing or full
        case (m_state_q)
            M_IDLE: begin
                if (rd_pend_q && (count_q < CNT_W'(DEPTH)) && !flush_i) begin
                    m_state_d = M_RD;
                end else if (count_q != '0) begin
                    m_state_d = M_WR;
                end
            end
            M_WR: begin
                if (mem_ready_i) begin
                    pop       = 1'b1;
                    m_state_d = M_IDLE;
                end
            end
            M_RD: begin
                if (mem_ready_i) begin
                    rd_pend_d = 1'b0;
                    m_state_d = M_IDLE;
                end
            end
            default: m_state_d = M_IDLE;
        endcase

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = up_tag;
            data_d[tail_q]  = up_wdata_i;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            u_state_q <= U_IDLE;
            m_state_q <= M_IDLE;
            valid_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            coal_q    <= '0;
            fwd_q     <= '0;
        end else begin
            u_state_q <= u_state_d;
            m_state_q <= m_state_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            coal_q    <= coal_d;
            fwd_q     <= fwd_d;
        end
    end

    // Outputs decode flops only; the head entry cannot change during its drain
    assign up_ready_o  = (u_state_q == U_RESP);
    assign up_rdata_o  = rdata_q;
    assign mem_valid_o = (m_state_q != M_IDLE);
    assign mem_rw_o    = (m_state_q == M_WR);
    assign mem_addr_o  = (m_state_q == M_WR) ? {tag_q[head_q], {OFFSET_W{1'b0}}} :
                         (m_state_q == M_RD) ? rd_addr_q : '0;
    assign mem_wdata_o = (m_state_q == M_WR) ? data_q[head_q] : '0;
    assign empty_o     = (count_q == '0) && (m_state_q != M_WR);
    assign count_o     = count_q;
    assign no_coal_o   = coal_q;
    assign no_fwd_o    = fwd_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: absorption, coalescing, forwarding,
// read priority, flush with pointer wrap, and asynchronous reset.
module tb_mem_write_buffer;

    logic         clk;
    logic         rst;
    logic         up_valid;
    logic         up_rw;
    logic [31:0]  up_addr;
    logic [127:0] up_wdata;
    logic         up_ready;
    logic [127:0] up_rdata;
    logic         mem_valid;
    logic         mem_rw;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         flush;
    logic         empty;
    logic [2:0]   count;
    logic [31:0]  no_coal;
    logic [31:0]  no_fwd;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_write_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .up_valid_i  (up_valid),
        .up_rw_i     (up_rw),
        .up_addr_i   (up_addr),
        .up_wdata_i  (up_wdata),
        .up_ready_o  (up_ready),
        .up_rdata_o  (up_rdata),
        .mem_valid_o (mem_valid),
        .mem_rw_o    (mem_rw),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata),
        .flush_i     (flush),
        .empty_o     (empty),
        .count_o     (count),
        .no_coal_o   (no_coal),
        .no_fwd_o    (no_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write expected to be accepted at the next edge; returns with upstream idle
    task automatic up_write(input string tag, input logic [31:0] a, input logic [127:0] d);
        up_valid = 1'b1;
        up_rw    = 1'b1;
        up_addr  = a;
        up_wdata = d;
        step();
        chk(tag, 128'(up_ready), 128'd1);
        up_valid = 1'b0;
        step();
    endtask

    // Checks the pending memory write, acknowledges it, and waits one cycle
    task automatic mem_ack(input string tag, input logic [31:0] a, input logic [127:0] d);
        chk({tag, "_vld"}, 128'({mem_valid, mem_rw}), 128'b11);
        chk({tag, "_addr"}, 128'(mem_addr), 128'(a));
        chk({tag, "_data"}, mem_wdata, d);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        up_valid  = 1'b0;
        up_rw     = 1'b0;
        up_addr   = '0;
        up_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        flush     = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_up_ready", 128'(up_ready), 128'd0);
        chk("rst_mem_valid", 128'(mem_valid), 128'd0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_counters", 128'({no_coal, no_fwd}), 128'd0);

        // Write absorption with memory stalled; fifth write waits for a pop
        up_write("t1_w100", 32'h100, 128'hD1);
        up_write("t1_w200", 32'h200, 128'hD2);
        up_write("t1_w300", 32'h300, 128'hD3);
        up_write("t1_w400", 32'h400, 128'hD4);
        chk("t1_count4", 128'(count), 128'd4);
        chk("t1_drain_addr", 128'(mem_addr), 128'h100);
        up_valid = 1'b1;
        up_rw    = 1'b1;
        up_addr  = 32'h500;
        up_wdata = 128'hD5;
        step();
        step();
        step();
        chk("t1_full_stall", 128'(up_ready), 128'd0);
        chk("t1_full_count", 128'(count), 128'd4);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t1_popedge_stall", 128'(up_ready), 128'd0);
        chk("t1_pop_count", 128'(count), 128'd3);
        step();
        chk("t1_w500_ready", 128'(up_ready), 128'd1);
        chk("t1_w500_count", 128'(count), 128'd4);
        up_valid = 1'b0;
        step();
        mem_ack("t1_m200", 32'h200, 128'hD2);
        mem_ack("t1_m300", 32'h300, 128'hD3);
        mem_ack("t1_m400", 32'h400, 128'hD4);
        mem_ack("t1_m500", 32'h500, 128'hD5);
        chk("t1_empty", 128'(empty), 128'd1);

        // Coalescing behind an in-flight drain of another line
        up_write("t2_w600", 32'h600, 128'hE0);
        up_write("t2_w100", 32'h100, 128'hA);
        up_write("t2_w104", 32'h104, 128'hB);
        chk("t2_count", 128'(count), 128'd2);
        chk("t2_coal", 128'(no_coal), 128'd1);
        mem_ack("t2_m600", 32'h600, 128'hE0);
        mem_ack("t2_m100", 32'h100, 128'hB);
        step();
        chk("t2_no_more_mem", 128'(mem_valid), 128'd0);
        chk("t2_empty", 128'(empty), 128'd1);

        // Forwarding from the in-flight head, then a write stalled on it
        up_write("t3_w200", 32'h200, 128'hC);
        up_valid = 1'b1;
        up_rw    = 1'b0;
        up_addr  = 32'h208;
        step();
        chk("t3_fwd_ready", 128'(up_ready), 128'd1);
        chk("t3_fwd_data", up_rdata, 128'hC);
        up_valid = 1'b0;
        step();
        chk("t3_fwd_cnt", 128'(no_fwd), 128'd1);
        chk("t3_no_mem_rd", 128'({mem_rw, mem_addr}), 128'({1'b1, 32'h200}));
        up_valid = 1'b1;
        up_rw    = 1'b1;
        up_addr  = 32'h200;
        up_wdata = 128'hC2;
        step();
        chk("t3_head_stall", 128'(up_ready), 128'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("t3_head_stall_pop", 128'(up_ready), 128'd0);
        step();
        chk("t3_after_pop_ready", 128'(up_ready), 128'd1);
        chk("t3_after_pop_count", 128'(count), 128'd1);
        chk("t3_after_pop_coal", 128'(no_coal), 128'd1);
        up_valid = 1'b0;
        step();
        mem_ack("t3_mC2", 32'h200, 128'hC2);

        // Read miss overtakes the second drain but not the one in flight
        up_write("t4_w700", 32'h700, 128'hF);
        up_write("t4_w800", 32'h800, 128'h6);
        up_valid = 1'b1;
        up_rw    = 1'b0;
        up_addr  = 32'h900;
        step();
        chk("t4_rd_wait", 128'(up_ready), 128'd0);
        chk("t4_drain_first", 128'({mem_rw, mem_addr}), 128'({1'b1, 32'h700}));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        chk("t4_mrd", 128'({mem_valid, mem_rw, mem_addr}), 128'({2'b10, 32'h900}));
        mem_ready = 1'b1;
        mem_rdata = 128'h1234_5678;
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("t4_rd_ready", 128'(up_ready), 128'd1);
        chk("t4_rd_data", up_rdata, 128'h1234_5678);
        chk("t4_fwd_unchanged", 128'(no_fwd), 128'd1);
        up_valid = 1'b0;
        step();
        mem_ack("t4_m800", 32'h800, 128'h6);
        chk("t4_empty", 128'(empty), 128'd1);

        // Six writes under flush, pointers wrap around the four entries
        flush = 1'b1;
        up_write("t5_wA00", 32'hA00, 128'h11);
        up_write("t5_wB00", 32'hB00, 128'h22);
        up_write("t5_wC00", 32'hC00, 128'h33);
        up_write("t5_wD00", 32'hD00, 128'h44);
        chk("t5_count4", 128'(count), 128'd4);
        mem_ack("t5_mA00", 32'hA00, 128'h11);
        mem_ack("t5_mB00", 32'hB00, 128'h22);
        up_write("t5_wE00", 32'hE00, 128'h55);
        up_write("t5_wF00", 32'hF00, 128'h66);
        mem_ack("t5_mC00", 32'hC00, 128'h33);
        mem_ack("t5_mD00", 32'hD00, 128'h44);
        mem_ack("t5_mE00", 32'hE00, 128'h55);
        mem_ack("t5_mF00", 32'hF00, 128'h66);
        chk("t5_empty", 128'(empty), 128'd1);
        chk("t5_count0", 128'(count), 128'd0);
        flush = 1'b0;

        // Reset asserted mid-drain, checked before the next clock edge
        up_write("t6_w1000", 32'h1000, 128'h77);
        chk("t6_inflight", 128'(mem_valid), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_mem_valid", 128'(mem_valid), 128'd0);
        chk("t6_async_count", 128'(count), 128'd0);
        chk("t6_async_empty", 128'(empty), 128'd1);
        chk("t6_async_counters", 128'({no_coal, no_fwd}), 128'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_stays_idle", 128'(mem_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
